mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data port of the memory controller between two requesters.
- M0 is the CPU load/store stage. M1 is a debug/DMA master.
- Grants one access per cycle: round-robin, with an optional M1 bus lock for bursts.
- Read data returns one cycle after issue, because the memory read is synchronous, and is steered back to the requester that issued the read.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 15, maximum consecutive cycles a requesting master may be denied (used only with ARB_STARVE_EN)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_req  in  1  M0 access request; held until granted
- i_m0_addr  in  ADDR_W  M0 byte address
- i_m0_wdata  in  DATA_W  M0 store data
- i_m0_width  in  2  access size: 1=byte, 2=half, 3=word
- i_m0_we  in  1  M0 write enable
- i_m0_zeroextend  in  1  M0 load zero-extend
- o_m0_gnt  out  1  M0 access issued this cycle
- o_m0_rvalid  out  1  M0 read data valid
- o_m0_rdata  out  DATA_W  M0 read data
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_width, i_m1_we, i_m1_zeroextend  in  as M0  M1 request fields
- i_m1_lock  in  1  M1 requests exclusive ownership across consecutive accesses
- o_m1_gnt, o_m1_rvalid, o_m1_rdata  out  as M0  M1 grant and response
- o_mem_valid  out  1  access issued to memory this cycle
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_width  out  2  memory access size
- o_mem_we  out  1  memory write enable, gated by o_mem_valid
- o_mem_zeroextend  out  1  memory load zero-extend
- i_mem_rdata  in  DATA_W  memory read data, valid the cycle after a read issue

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, last_grant=M1 (so M0 wins the first tie).
  - rd_pending=0, all rvalid=0.
  - Grants combinationally 0 while in reset.
- States and transitions:
  - IDLE:
    - neither requests → stay, o_mem_valid=0.
    - exactly one requests → grant it.
    - both request → grant the master not equal to last_grant.
    - M1 granted with i_m1_lock=1 → go LOCKED.
  - LOCKED:
    - M1 has absolute priority; M0 is denied even if requesting.
    - i_m1_lock=0 on a granted access, or i_m1_req=0 → return to IDLE next cycle.
    - Return to IDLE sets last_grant=M1.
- Grant timing:
  - o_mX_gnt is combinational, same cycle as o_mem_valid.
  - At most one gnt high per cycle.
  - Memory fields are muxed from the granted master; all are 0 when idle.
- Grant ordering:
  - last_grant updates on every granted cycle.
  - Two continuous requesters in IDLE alternate 0,1,0,1…
- Read response:
  - On a granted read (we=0), register rd_pending=1 and rd_owner.
  - Next cycle: o_m{rd_owner}_rvalid=1 for exactly one cycle, o_m{rd_owner}_rdata=i_mem_rdata.
  - Both rdata outputs are 0 when the matching rvalid is low.
  - A write gives no rvalid.
- Back-to-back: a new grant can issue in the same cycle a previous read response returns; the pipeline is full throughput.
- Request rules: a request dropped before grant is allowed and is simply not issued. Request fields must be stable while req=1 and ungranted.
- Reset mid-access: a pending read response is discarded (no rvalid after reset release). State returns to IDLE.
- Width: access size is passed through unchanged. The arbiter performs no alignment checks.

Optional Feature:
- Macro ARB_STARVE_EN.
- Defined:
  - A per-master 4-bit wait counter increments each cycle the master requests and is not granted.
  - The counter clears on grant or when req drops.
  - When M0's counter reaches STARVE_LIMIT while in LOCKED, the next arbitration force-grants M0 once, overriding the lock.
  - The state stays LOCKED after the forced grant.
- Undefined: counters are absent and the lock is absolute.

Test Plan:
- Single M0 read, addr 0x40000010 width 3: o_m0_gnt=1 and o_mem_valid=1 same cycle; next cycle o_m0_rvalid=1, o_m0_rdata=i_mem_rdata (drive 0xDEADBEEF); o_m1_rvalid=0.
- Both request continuously from reset for 6 cycles: grants M0,M1,M0,M1,M0,M1; rvalid routed to the matching owner each cycle.
- M1 write with lock=1 for 4 accesses while M0 requests: 4 consecutive o_m1_gnt, o_m0_gnt=0. Lock released → M0 granted next cycle.
- Assert i_rst_n=0 the cycle after an M0 read grant: no o_m0_rvalid after release; state IDLE; first tie grants M0.
- M0 store 0x12345678 to 0x40000004: o_mem_we=1 and o_mem_wdata=0x12345678 in the grant cycle; no rvalid follows.
- ARB_STARVE_EN, STARVE_LIMIT=3, M1 locked with M0 requesting: M0 is force-granted within 4 cycles, then M1 resumes.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single data port of the memory controller between two masters:
//   M0 - CPU load/store stage
//   M1 - debug/DMA master, may lock the port for bursts
// One access is issued per cycle. Arbitration is round-robin in IDLE; while
// M1 holds the lock (LOCKED) it has absolute priority. Read data returns the
// cycle after issue and is steered back to the master that issued the read.
//
// Optional feature macro: ARB_STARVE_EN
//   When defined, per-master wait counters are kept and M0 is force-granted
//   once through an M1 lock after waiting STARVE_LIMIT cycles.
//   When undefined, the lock is absolute.
//
// Parameters
//   ADDR_W        address width
//   DATA_W        data width
//   STARVE_LIMIT  max consecutive denied cycles for M0 under lock (1..15)
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_mX_req/addr/wdata/width/we/zeroextend   request fields of master X
//   i_m1_lock                      M1 exclusive-ownership request
//   o_mX_gnt                       access issued for master X this cycle
//   o_mX_rvalid, o_mX_rdata        read response for master X (rdata 0 when
//                                  rvalid is low)
//   o_mem_valid/addr/wdata/width/we/zeroextend  access to memory
//   i_mem_rdata                    memory read data, cycle after read issue
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | round-robin between M0 and M1, last_grant breaks ties
// LOCKED | M1 owns the port; M0 denied (unless force-granted for starvation)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [1:0]        i_m0_width,
    input  logic              i_m0_we,
    input  logic              i_m0_zeroextend,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [1:0]        i_m1_width,
    input  logic              i_m1_we,
    input  logic              i_m1_zeroextend,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,

    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [1:0]        o_mem_width,
    output logic              o_mem_we,
    output logic              o_mem_zeroextend,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // The wait counters are 4 bits wide, so the limit must fit in them.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic [0:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       rd_pending_q;
    logic       rd_owner_q;
    logic       gnt_m0, gnt_m1;
    logic       force_m0;

`ifdef ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_m0_q;
    logic [3:0] wait_m1_q;

    // Counter reaching the limit during a lock lets M0 through exactly once;
    // the grant clears the counter so the override cannot repeat back to back.
    assign force_m0 = (state_q == ST_LOCKED) && i_m0_req && (wait_m0_q >= LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_m0_q <= 4'd0;
            wait_m1_q <= 4'd0;
        end else begin
            if (i_m0_req && !gnt_m0) begin
                if (wait_m0_q != 4'hF) wait_m0_q <= wait_m0_q + 4'd1;
            end else begin
                wait_m0_q <= 4'd0;
            end
            if (i_m1_req && !gnt_m1) begin
                if (wait_m1_q != 4'hF) wait_m1_q <= wait_m1_q + 4'd1;
            end else begin
                wait_m1_q <= 4'd0;
            end
        end
    end
`else
    assign force_m0 = 1'b0;
`endif

    // Grant decision. Held at zero during reset so nothing reaches memory
    // while the sequential state is being cleared.
    always_comb begin
        gnt_m0 = 1'b0;
        gnt_m1 = 1'b0;
        if (i_rst_n) begin
            if (state_q == ST_LOCKED) begin
                if (force_m0) begin
                    gnt_m0 = 1'b1;
                end else if (i_m1_req) begin
                    gnt_m1 = 1'b1;
                end
            end else begin
                if (i_m0_req && i_m1_req) begin
                    if (last_grant_q == OWNER_M1) gnt_m0 = 1'b1;
                    else                          gnt_m1 = 1'b1;
                end else if (i_m0_req) begin
                    gnt_m0 = 1'b1;
                end else if (i_m1_req) begin
                    gnt_m1 = 1'b1;
                end
            end
        end
    end

    assign o_m0_gnt = gnt_m0;
    assign o_m1_gnt = gnt_m1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (gnt_m0) begin
            last_grant_d = OWNER_M0;
        end else if (gnt_m1) begin
            last_grant_d = OWNER_M1;
        end
        if (state_q == ST_IDLE) begin
            if (gnt_m1 && i_m1_lock) state_d = ST_LOCKED;
        end else begin
            // A forced M0 grant is not an M1 access, so it never ends the lock.
            if (!i_m1_req || (gnt_m1 && !i_m1_lock)) begin
                state_d      = ST_IDLE;
                last_grant_d = OWNER_M1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWNER_M1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Memory-side mux; every field is zero when nothing is issued.
    always_comb begin
        o_mem_valid      = 1'b0;
        o_mem_addr       = '0;
        o_mem_wdata      = '0;
        o_mem_width      = 2'd0;
        o_mem_we         = 1'b0;
        o_mem_zeroextend = 1'b0;
        if (gnt_m0) begin
            o_mem_valid      = 1'b1;
            o_mem_addr       = i_m0_addr;
            o_mem_wdata      = i_m0_wdata;
            o_mem_width      = i_m0_width;
            o_mem_we         = i_m0_we;
            o_mem_zeroextend = i_m0_zeroextend;
        end else if (gnt_m1) begin
            o_mem_valid      = 1'b1;
            o_mem_addr       = i_m1_addr;
            o_mem_wdata      = i_m1_wdata;
            o_mem_width      = i_m1_width;
            o_mem_we         = i_m1_we;
            o_mem_zeroextend = i_m1_zeroextend;
        end
    end

    // Read response tracking: one slot suffices because memory answers in
    // exactly one cycle, so a new read can issue while the previous returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWNER_M0;
        end else begin
            rd_pending_q <= o_mem_valid && !o_mem_we;
            if (o_mem_valid) rd_owner_q <= gnt_m1;
        end
    end

    assign o_m0_rvalid = rd_pending_q && (rd_owner_q == OWNER_M0);
    assign o_m1_rvalid = rd_pending_q && (rd_owner_q == OWNER_M1);
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_m0_req, i_m0_we, i_m0_zeroextend;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    logic [1:0]        i_m0_width;
    logic              o_m0_gnt, o_m0_rvalid;
    logic [DATA_W-1:0] o_m0_rdata;
    logic              i_m1_req, i_m1_we, i_m1_zeroextend, i_m1_lock;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    logic [1:0]        i_m1_width;
    logic              o_m1_gnt, o_m1_rvalid;
    logic [DATA_W-1:0] o_m1_rdata;
    logic              o_mem_valid, o_mem_we, o_mem_zeroextend;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [1:0]        o_mem_width;
    logic [DATA_W-1:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(3)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .i_m0_width(i_m0_width), .i_m0_we(i_m0_we), .i_m0_zeroextend(i_m0_zeroextend),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .i_m1_width(i_m1_width), .i_m1_we(i_m1_we), .i_m1_zeroextend(i_m1_zeroextend),
        .i_m1_lock(i_m1_lock),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_width(o_mem_width), .o_mem_we(o_mem_we),
        .o_mem_zeroextend(o_mem_zeroextend), .i_mem_rdata(i_mem_rdata)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        i_m0_req = 0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_width = 2'd0;
        i_m0_we = 0; i_m0_zeroextend = 0;
        i_m1_req = 0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_width = 2'd0;
        i_m1_we = 0; i_m1_zeroextend = 0; i_m1_lock = 0;
    endtask

    task automatic apply_reset();
        next_cycle();
        clear_inputs();
        i_rst_n = 0;
        next_cycle();
        next_cycle();
        i_rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_mem_rdata = 32'hFFFF_FFFF;
        i_rst_n = 0;
        i_m0_req = 1; i_m0_addr = 32'h1111_0000;
        i_m1_req = 1; i_m1_addr = 32'h2222_0000;
        #4;
        total++; if (o_m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_m0_gnt got=%b exp=0", o_m0_gnt); end
        total++; if (o_m1_gnt !== 1'b0) begin bad++; $display("FAIL reset_m1_gnt got=%b exp=0", o_m1_gnt); end
        total++; if (o_mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", o_mem_valid); end
        total++; if (o_mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
        total++; if ({o_m0_rvalid, o_m1_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {o_m0_rvalid, o_m1_rvalid}); end
        total++; if (o_m0_rdata !== 32'h0) begin bad++; $display("FAIL reset_m0_rdata got=%h exp=0", o_m0_rdata); end
        clear_inputs();
        next_cycle();
        next_cycle();
        i_rst_n = 1;
    endtask

    task automatic test_single_read();
        next_cycle();
        i_m0_req = 1; i_m0_addr = 32'h4000_0010; i_m0_width = 2'd3; i_m0_we = 0;
        settle();
        total++; if (o_m0_gnt !== 1'b1) begin bad++; $display("FAIL rd_m0_gnt got=%b exp=1", o_m0_gnt); end
        total++; if (o_m1_gnt !== 1'b0) begin bad++; $display("FAIL rd_m1_gnt got=%b exp=0", o_m1_gnt); end
        total++; if (o_mem_valid !== 1'b1) begin bad++; $display("FAIL rd_mem_valid got=%b exp=1", o_mem_valid); end
        total++; if (o_mem_addr !== 32'h4000_0010) begin bad++; $display("FAIL rd_mem_addr got=%h exp=40000010", o_mem_addr); end
        total++; if (o_mem_width !== 2'd3) begin bad++; $display("FAIL rd_mem_width got=%0d exp=3", o_mem_width); end
        total++; if (o_mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%b exp=0", o_mem_we); end
        next_cycle();
        clear_inputs();
        i_mem_rdata = 32'hDEAD_BEEF;
        settle();
        total++; if (o_m0_rvalid !== 1'b1) begin bad++; $display("FAIL rd_m0_rvalid got=%b exp=1", o_m0_rvalid); end
        total++; if (o_m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_m0_rdata got=%h exp=deadbeef", o_m0_rdata); end
        total++; if (o_m1_rvalid !== 1'b0) begin bad++; $display("FAIL rd_m1_rvalid got=%b exp=0", o_m1_rvalid); end
        total++; if (o_m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_m1_rdata got=%h exp=0", o_m1_rdata); end
        total++; if (o_mem_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_valid got=%b exp=0", o_mem_valid); end
        next_cycle();
        settle();
        total++; if (o_m0_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_once got=%b exp=0", o_m0_rvalid); end
        total++; if (o_m0_rdata !== 32'h0) begin bad++; $display("FAIL rd_rdata_zero got=%h exp=0", o_m0_rdata); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            i_m0_req = 1; i_m0_addr = 32'h0000_1000; i_m0_width = 2'd3;
            i_m1_req = 1; i_m1_addr = 32'h0000_2000; i_m1_width = 2'd2;
            i_mem_rdata = 32'hA000_0000 + i;
            settle();
            exp0 = (i % 2 == 0);
            total++; if (o_m0_gnt !== exp0) begin bad++; $display("FAIL rr_m0_gnt[%0d] got=%b exp=%b", i, o_m0_gnt, exp0); end
            total++; if (o_m1_gnt !== !exp0) begin bad++; $display("FAIL rr_m1_gnt[%0d] got=%b exp=%b", i, o_m1_gnt, !exp0); end
            total++; if (o_mem_addr !== (exp0 ? 32'h0000_1000 : 32'h0000_2000)) begin bad++; $display("FAIL rr_addr[%0d] got=%h", i, o_mem_addr); end
            if (i > 0) begin
                total++; if (o_m0_rvalid !== !exp0) begin bad++; $display("FAIL rr_m0_rvalid[%0d] got=%b exp=%b", i, o_m0_rvalid, !exp0); end
                total++; if (o_m1_rvalid !== exp0) begin bad++; $display("FAIL rr_m1_rvalid[%0d] got=%b exp=%b", i, o_m1_rvalid, exp0); end
                total++; if ((exp0 ? o_m1_rdata : o_m0_rdata) !== 32'hA000_0000 + i) begin bad++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, exp0 ? o_m1_rdata : o_m0_rdata, 32'hA000_0000 + i); end
            end
        end
        next_cycle();
        clear_inputs();
        i_mem_rdata = 32'hA000_0006;
        settle();
        total++; if (o_m1_rvalid !== 1'b1) begin bad++; $display("FAIL rr_last_m1_rvalid got=%b exp=1", o_m1_rvalid); end
        total++; if (o_m1_rdata !== 32'hA000_0006) begin bad++; $display("FAIL rr_last_m1_rdata got=%h exp=a0000006", o_m1_rdata); end
    endtask

    task automatic test_write();
        next_cycle();
        i_m0_req = 1; i_m0_addr = 32'h4000_0004; i_m0_wdata = 32'h1234_5678;
        i_m0_width = 2'd3; i_m0_we = 1;
        settle();
        total++; if (o_m0_gnt !== 1'b1) begin bad++; $display("FAIL wr_m0_gnt got=%b exp=1", o_m0_gnt); end
        total++; if (o_mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we got=%b exp=1", o_mem_we); end
        total++; if (o_mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_mem_wdata got=%h exp=12345678", o_mem_wdata); end
        total++; if (o_mem_addr !== 32'h4000_0004) begin bad++; $display("FAIL wr_mem_addr got=%h exp=40000004", o_mem_addr); end
        next_cycle();
        clear_inputs();
        i_mem_rdata = 32'hBAD0_BAD0;
        settle();
        total++; if ({o_m0_rvalid, o_m1_rvalid} !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=00", {o_m0_rvalid, o_m1_rvalid}); end
        total++; if (o_m0_rdata !== 32'h0) begin bad++; $display("FAIL wr_m0_rdata got=%h exp=0", o_m0_rdata); end
    endtask

    task automatic test_m1_read();
        next_cycle();
        i_m1_req = 1; i_m1_addr = 32'h2000_0003; i_m1_width = 2'd1;
        i_m1_we = 0; i_m1_zeroextend = 1;
        settle();
        total++; if (o_m1_gnt !== 1'b1) begin bad++; $display("FAIL m1rd_gnt got=%b exp=1", o_m1_gnt); end
        total++; if (o_mem_width !== 2'd1) begin bad++; $display("FAIL m1rd_width got=%0d exp=1", o_mem_width); end
        total++; if (o_mem_zeroextend !== 1'b1) begin bad++; $display("FAIL m1rd_zx got=%b exp=1", o_mem_zeroextend); end
        total++; if (o_mem_addr !== 32'h2000_0003) begin bad++; $display("FAIL m1rd_addr got=%h exp=20000003", o_mem_addr); end
        next_cycle();
        clear_inputs();
        i_mem_rdata = 32'h0000_00A5;
        settle();
        total++; if (o_m1_rvalid !== 1'b1) begin bad++; $display("FAIL m1rd_rvalid got=%b exp=1", o_m1_rvalid); end
        total++; if (o_m1_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL m1rd_rdata got=%h exp=a5", o_m1_rdata); end
        total++; if (o_m0_rvalid !== 1'b0) begin bad++; $display("FAIL m1rd_m0_rvalid got=%b exp=0", o_m0_rvalid); end
    endtask

    task automatic test_idle_fields();
        next_cycle();
        clear_inputs();
        i_m0_addr = 32'hCAFE_0000; i_m0_wdata = 32'h5555_5555; i_m0_width = 2'd3; i_m0_we = 1;
        i_m1_addr = 32'hBEEF_0000; i_m1_zeroextend = 1; i_m1_we = 1;
        settle();
        total++; if (o_mem_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", o_mem_valid); end
        total++; if ({o_mem_addr, o_mem_wdata} !== 64'h0) begin bad++; $display("FAIL idle_addr_wdata got=%h exp=0", {o_mem_addr, o_mem_wdata}); end
        total++; if ({o_mem_width, o_mem_we, o_mem_zeroextend} !== 4'h0) begin bad++; $display("FAIL idle_ctrl got=%h exp=0", {o_mem_width, o_mem_we, o_mem_zeroextend}); end
        clear_inputs();
    endtask

    task automatic test_lock();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            i_m1_req = (k < 4); i_m1_we = 1; i_m1_wdata = 32'hC0DE_0000 + k;
            i_m1_addr = 32'h3000_0000 + 4 * k; i_m1_width = 2'd3;
            i_m1_lock = (k < 3);
            i_m0_req = (k >= 1); i_m0_addr = 32'h4000_0020; i_m0_width = 2'd3; i_m0_we = 0;
            settle();
            total++; if (o_m1_gnt !== (k < 4)) begin bad++; $display("FAIL lock_m1_gnt[%0d] got=%b exp=%b", k, o_m1_gnt, k < 4); end
            total++; if (o_m0_gnt !== (k == 4)) begin bad++; $display("FAIL lock_m0_gnt[%0d] got=%b exp=%b", k, o_m0_gnt, k == 4); end
            total++; if ({o_m0_rvalid, o_m1_rvalid} !== 2'b00) begin bad++; $display("FAIL lock_rvalid[%0d] got=%b exp=00", k, {o_m0_rvalid, o_m1_rvalid}); end
        end
        next_cycle();
        clear_inputs();
        i_mem_rdata = 32'h7777_0000;
        settle();
        total++; if (o_m0_rvalid !== 1'b1) begin bad++; $display("FAIL lock_m0_rvalid got=%b exp=1", o_m0_rvalid); end
    endtask

    task automatic test_starve();
        logic starve_en;
        logic exp0;
`ifdef ARB_STARVE_EN
        starve_en = 1'b1;
`else
        starve_en = 1'b0;
`endif
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cycle();
            i_m1_req = (k < 8); i_m1_lock = (k < 7); i_m1_we = 1;
            i_m1_addr = 32'h5000_0000; i_m1_width = 2'd3;
            i_m0_req = (k >= 1); i_m0_we = 1; i_m0_addr = 32'h6000_0000; i_m0_width = 2'd3;
            settle();
            // M0 waits k=1..3; with the feature it is forced through at k=4.
            exp0 = (starve_en && k == 4) || (k == 8);
            total++; if (o_m0_gnt !== exp0) begin bad++; $display("FAIL starve_m0_gnt[%0d] got=%b exp=%b", k, o_m0_gnt, exp0); end
            total++; if (o_m1_gnt !== (!exp0 && k < 8)) begin bad++; $display("FAIL starve_m1_gnt[%0d] got=%b exp=%b", k, o_m1_gnt, !exp0 && k < 8); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        i_m0_req = 1; i_m0_addr = 32'h4000_0030; i_m0_width = 2'd3; i_m0_we = 0;
        settle();
        total++; if (o_m0_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", o_m0_gnt); end
        next_cycle();
        clear_inputs();
        i_rst_n = 0;
        i_mem_rdata = 32'h55AA_55AA;
        settle();
        total++; if (o_m0_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid_in_reset got=%b exp=0", o_m0_rvalid); end
        next_cycle();
        i_rst_n = 1;
        settle();
        total++; if (o_m0_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid_after got=%b exp=0", o_m0_rvalid); end
        total++; if (o_m0_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata_after got=%h exp=0", o_m0_rdata); end
        next_cycle();
        i_m0_req = 1; i_m1_req = 1; i_m0_we = 1; i_m1_we = 1;
        settle();
        total++; if (o_m0_gnt !== 1'b1) begin bad++; $display("FAIL rmid_tie_m0 got=%b exp=1", o_m0_gnt); end
        total++; if (o_m1_gnt !== 1'b0) begin bad++; $display("FAIL rmid_tie_m1 got=%b exp=0", o_m1_gnt); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_m1_read();
        test_idle_fields();
        test_lock();
        test_starve();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
